// File: rtl/board_led_ctrl_if.sv
// board_led_ctrl_if: drop request / result bus between the game FSM and the board store
//   drop_valid, drop_col, player : request from master
//   drop_ready                   : slave can accept a drop
//   placed, placed_row           : token written pulse and its landing row
//   drop_err                     : drop rejected pulse (full or invalid column)
interface board_led_ctrl_if #(
    parameter int ROWS = 6,
    parameter int COLS = 7,
    parameter int RW   = $clog2(ROWS),
    parameter int CW   = $clog2(COLS)
);
    logic          drop_valid;
    logic          drop_ready;
    logic [CW-1:0] drop_col;
    logic          player;
    logic          placed;
    logic [RW-1:0] placed_row;
    logic          drop_err;
    modport master (output drop_valid, drop_col, player, input drop_ready, placed, placed_row, drop_err);
    modport slave  (input drop_valid, drop_col, player, output drop_ready, placed, placed_row, drop_err);
endinterface

// File: rtl/board_led_ctrl.sv
// board_led_ctrl: Connect Four board store with gravity drop and multiplexed red/green LED row scan
//   clk, reset          : clock, asynchronous active-high reset
//   clear               : synchronous new-game pulse
//   bus (slave)         : drop request / placed / drop_err handshake
//   board_full          : all cells occupied
//   disp_row            : row currently driven on the matrix
//   red_row, grn_row    : LED column enables for disp_row
module board_led_ctrl #(
    parameter int ROWS      = 6,
    parameter int COLS      = 7,
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 25000000,
    parameter int RW        = $clog2(ROWS),
    parameter int CW        = $clog2(COLS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    board_led_ctrl_if.slave bus,
    output logic            board_full,
    output logic [RW-1:0]   disp_row,
    output logic [COLS-1:0] red_row,
    output logic [COLS-1:0] grn_row
);
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam int TW = $clog2(ROWS * COLS + 1);

    typedef enum logic [1:0] {IDLE, SEARCH, CLEAR} state_t;

    state_t                     state;
    logic [ROWS-1:0][COLS-1:0]  occ;
    logic [ROWS-1:0][COLS-1:0]  colr;
    logic [RW-1:0]              srow;
    logic [RW-1:0]              clr_row;
    logic [CW-1:0]              col;
    logic                       ply;
    logic [TW-1:0]              cnt;
    logic [RW-1:0]              last_row;
    logic [CW-1:0]              last_col;
    logic                       last_valid;
    logic [SW-1:0]              scan_cnt;
    logic [BW-1:0]              blink_cnt;
    logic                       blink_phase;
    logic [COLS-1:0]            hide;

    assign bus.drop_ready = state == IDLE && !clear;
    assign board_full     = cnt == TW'(ROWS * COLS);

    // the last-placed cell goes dark during the off half of the blink
    assign hide    = (last_valid && disp_row == last_row && !blink_phase) ? COLS'(1) << last_col : '0;
    assign red_row = occ[disp_row] & ~colr[disp_row] & ~hide;
    assign grn_row = occ[disp_row] & colr[disp_row] & ~hide;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            occ            <= '0;
            colr           <= '0;
            srow           <= '0;
            clr_row        <= '0;
            col            <= '0;
            ply            <= 1'b0;
            cnt            <= '0;
            last_row       <= '0;
            last_col       <= '0;
            last_valid     <= 1'b0;
            bus.placed     <= 1'b0;
            bus.placed_row <= '0;
            bus.drop_err   <= 1'b0;
        end else begin
            bus.placed   <= 1'b0;
            bus.drop_err <= 1'b0;
            if (clear) begin
                state      <= CLEAR;
                clr_row    <= '0;
                cnt        <= '0;
                last_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (bus.drop_valid) begin
                        if (int'(bus.drop_col) < COLS) begin
                            state <= SEARCH;
                            col   <= bus.drop_col;
                            ply   <= bus.player;
                            srow  <= '0;
                        end else begin
                            bus.drop_err <= 1'b1;
                        end
                    end
                    SEARCH: if (!occ[srow][col]) begin
                        occ[srow][col]  <= 1'b1;
                        colr[srow][col] <= ply;
                        bus.placed      <= 1'b1;
                        bus.placed_row  <= srow;
                        last_row        <= srow;
                        last_col        <= col;
                        last_valid      <= 1'b1;
                        cnt             <= cnt + 1'b1;
                        state           <= IDLE;
                    end else if (srow == RW'(ROWS - 1)) begin
                        bus.drop_err <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        srow <= srow + 1'b1;
                    end
                    CLEAR: begin
                        occ[clr_row]  <= '0;
                        colr[clr_row] <= '0;
                        clr_row       <= clr_row + 1'b1;
                        state         <= clr_row == RW'(ROWS - 1) ? IDLE : CLEAR;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt    <= '0;
            disp_row    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            scan_cnt    <= scan_cnt == SW'(SCAN_DIV - 1) ? '0 : scan_cnt + 1'b1;
            blink_cnt   <= blink_cnt == BW'(BLINK_DIV - 1) ? '0 : blink_cnt + 1'b1;
            blink_phase <= blink_cnt == BW'(BLINK_DIV - 1) ? !blink_phase : blink_phase;
            if (scan_cnt == SW'(SCAN_DIV - 1))
                disp_row <= disp_row == RW'(ROWS - 1) ? '0 : disp_row + 1'b1;
        end
    end
endmodule

// File: tb/tb_board_led_ctrl.sv
// tb_board_led_ctrl: directed self-checking bench for board_led_ctrl with a small board/display model
module tb_board_led_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       board_full;
    logic [2:0] disp_row;
    logic [6:0] red_row, grn_row;
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc;
    bit         m_occ [6][7];
    bit         m_clr [6][7];
    bit         m_lv;
    int         m_lr, m_lc;

    board_led_ctrl_if #(.ROWS(6), .COLS(7)) bus ();

    board_led_ctrl #(.ROWS(6), .COLS(7), .SCAN_DIV(2), .BLINK_DIV(4)) dut (
        .clk(clk), .reset(reset), .clear(clear), .bus(bus.slave),
        .board_full(board_full), .disp_row(disp_row), .red_row(red_row), .grn_row(grn_row)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset)
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        foreach (m_occ[r, c]) begin
            m_occ[r][c] = 1'b0;
            m_clr[r][c] = 1'b0;
        end
        m_lv = 1'b0;
    endtask

    task automatic disp_chk();
        int d;
        bit ph;
        logic [6:0] er, eg;
        d = (cyc / 2) % 6;
        ph = ((cyc / 4) % 2) == 1;
        for (int c = 0; c < 7; c++) begin
            er[c] = m_occ[d][c] & ~m_clr[d][c];
            eg[c] = m_occ[d][c] & m_clr[d][c];
            if (m_lv && d == m_lr && c == m_lc && !ph) begin
                er[c] = 1'b0;
                eg[c] = 1'b0;
            end
        end
        chk("disp_row", disp_row, d);
        chk("red_row", red_row, er);
        chk("grn_row", grn_row, eg);
    endtask

    task automatic disp_loop(input int n);
        repeat (n) begin
            disp_chk();
            tick();
        end
    endtask

    // exp_row < 0 means the drop must be rejected
    task automatic drop(input int c, input bit p, input int exp_row, input int exp_lat);
        int lat;
        logic [2:0] cv;
        cv = c[2:0];
        bus.drop_valid = 1'b1;
        bus.drop_col = cv;
        bus.player = p;
        #1;
        chk("drop_ready", bus.drop_ready, 1);
        tick();
        bus.drop_valid = 1'b0;
        lat = 0;
        while (!(bus.placed || bus.drop_err) && lat < 10) begin
            tick();
            lat++;
        end
        chk("latency", lat, exp_lat);
        if (exp_row >= 0) begin
            chk("placed", bus.placed, 1);
            chk("placed_row", bus.placed_row, exp_row);
            m_occ[exp_row][c] = 1'b1;
            m_clr[exp_row][c] = p;
            m_lv = 1'b1;
            m_lr = exp_row;
            m_lc = c;
        end else begin
            chk("drop_err", bus.drop_err, 1);
            chk("no_placed", bus.placed, 0);
        end
        chk("ready_back", bus.drop_ready, 1);
        tick();
        chk("pulse_end", {bus.placed, bus.drop_err}, 0);
    endtask

    initial begin
        bus.drop_valid = 1'b0;
        bus.drop_col = '0;
        bus.player = 1'b0;
        model_clear();
        #12 reset = 1'b0;
        chk("rst_placed", bus.placed, 0);
        chk("rst_drop_err", bus.drop_err, 0);
        chk("rst_placed_row", bus.placed_row, 0);
        chk("rst_board_full", board_full, 0);
        chk("rst_ready", bus.drop_ready, 1);
        disp_chk();
        tick();

        drop(3, 0, 0, 1);
        disp_loop(24);

        for (int i = 0; i < 6; i++) drop(2, i[0], i, i + 1);
        drop(2, 0, -1, 6);
        disp_loop(12);

        drop(7, 1, -1, 0);
        disp_loop(4);

        clear = 1'b1;
        bus.drop_valid = 1'b1;
        bus.drop_col = 3'd4;
        #1;
        chk("clear_blocks_ready", bus.drop_ready, 0);
        tick();
        clear = 1'b0;
        bus.drop_valid = 1'b0;
        chk("clear_no_placed", bus.placed, 0);
        model_clear();
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("clear_ready", bus.drop_ready, i == 6);
        end
        chk("clear_full", board_full, 0);
        disp_loop(12);

        for (int i = 0; i < 4; i++) drop(0, ~i[0], i, i + 1);
        bus.drop_valid = 1'b1;
        bus.drop_col = 3'd0;
        bus.player = 1'b1;
        tick();
        bus.drop_valid = 1'b0;
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
        for (int i = 0; i < 10; i++) begin
            chk("abort_quiet", {bus.placed, bus.drop_err}, 0);
            tick();
        end
        chk("abort_full", board_full, 0);
        disp_loop(12);
        drop(0, 1, 0, 1);

        for (int c = 0; c < 7; c++)
            for (int r = (c == 0) ? 1 : 0; r < 6; r++) begin
                if (c == 6 && r == 5) chk("full_before", board_full, 0);
                drop(c, (c + r) % 2 == 1, r, r + 1);
            end
        chk("full_after", board_full, 1);
        disp_loop(12);
        drop(5, 0, -1, 6);
        chk("full_stays", board_full, 1);

        bus.drop_valid = 1'b1;
        bus.drop_col = 3'd1;
        tick();
        bus.drop_valid = 1'b0;
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_placed", bus.placed, 0);
        chk("arst_drop_err", bus.drop_err, 0);
        chk("arst_placed_row", bus.placed_row, 0);
        chk("arst_full", board_full, 0);
        chk("arst_disp_row", disp_row, 0);
        chk("arst_red", red_row, 0);
        chk("arst_grn", grn_row, 0);
        chk("arst_ready", bus.drop_ready, 1);
        #2 reset = 1'b0;
        model_clear();
        tick();
        disp_loop(12);
        drop(4, 0, 0, 1);
        disp_loop(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
